// File: rtl/touch_frame_sync_pkg.sv
// Shared definitions for the touch_frame_sync slice: FSM state encoding, default
// thresholds/offsets and the TFT panel limits.
package touch_frame_sync_pkg;

  // Encoding is visible on the fsm_state debug port, so the values are fixed.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDebP  = 2'd1,
    StTrack = 2'd2,
    StDebR  = 2'd3
  } touch_state_e;

  localparam int unsigned DefRawW     = 12;
  localparam int unsigned DefZThresh  = 256;
  localparam int unsigned DefXOffset  = 150;
  localparam int unsigned DefYOffset  = 300;
  localparam int unsigned DefShift    = 3;
  localparam int unsigned DefDebounce = 4;
  localparam int unsigned DefAvgLog2  = 2;

  // 480x272 panel
  localparam int unsigned DefXMax = 479;
  localparam int unsigned DefYMax = 271;

  localparam int unsigned DispXW = 10;
  localparam int unsigned DispYW = 9;

endpackage

// File: rtl/touch_calib.sv
// Per-axis calibration: saturating offset subtract, right shift to pixel scale,
// clamp to the largest legal pixel. Purely combinational.
//   avg  in   IN_W   averaged raw coordinate
//   pix  out  OUT_W  calibrated pixel coordinate, never above MAX
module touch_calib #(
  parameter int unsigned IN_W   = 12,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned OFFSET = 150,
  parameter int unsigned SHIFT  = 3,
  parameter int unsigned MAX    = 479
) (
  input  logic [IN_W-1:0]  avg,
  output logic [OUT_W-1:0] pix
);

  logic [IN_W-1:0] diff;
  logic [IN_W-1:0] scaled;

  always_comb begin
    diff   = (avg >= IN_W'(OFFSET)) ? (avg - IN_W'(OFFSET)) : '0;
    scaled = diff >> SHIFT;
    pix    = (scaled > IN_W'(MAX)) ? OUT_W'(MAX) : OUT_W'(scaled);
  end

endmodule

// File: rtl/touch_frame_sync.sv
// Turns raw touchpad samples into stable screen coordinates for the TFT driver.
// Debounces press/release, averages 2^AVG_LOG2 samples, calibrates them into a
// pending slot and only commits the pending slot to the display on new_frame.
//   cclk, reset            clock, synchronous active-high reset
//   sample_stb, raw_x/y/z  new raw sample strobe and data
//   new_frame              frame-start pulse from the TFT
//   disp_x/y, disp_valid   committed coordinates and active-touch flag
//   press_evt/release_evt  one-cycle debounced event pulses
//   fsm_state              current state, debug
module touch_frame_sync
  import touch_frame_sync_pkg::*;
#(
  parameter int unsigned RAW_W    = DefRawW,
  parameter int unsigned Z_THRESH = DefZThresh,
  parameter int unsigned X_OFFSET = DefXOffset,
  parameter int unsigned Y_OFFSET = DefYOffset,
  parameter int unsigned SHIFT    = DefShift,
  parameter int unsigned DEBOUNCE = DefDebounce,
  parameter int unsigned AVG_LOG2 = DefAvgLog2,
  parameter int unsigned X_MAX    = DefXMax,
  parameter int unsigned Y_MAX    = DefYMax
) (
  input  logic              cclk,
  input  logic              reset,
  input  logic              sample_stb,
  input  logic [RAW_W-1:0]  raw_x,
  input  logic [RAW_W-1:0]  raw_y,
  input  logic [RAW_W-1:0]  raw_z,
  input  logic              new_frame,
  output logic [DispXW-1:0] disp_x,
  output logic [DispYW-1:0] disp_y,
  output logic              disp_valid,
  output logic              press_evt,
  output logic              release_evt,
  output logic [1:0]        fsm_state
);

  localparam int unsigned AccW  = RAW_W + AVG_LOG2;
  localparam int unsigned DcntW = $clog2(DEBOUNCE + 1);
  localparam int unsigned ScntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE - 1);
  localparam logic [ScntW-1:0] ScntLast = ScntW'((1 << AVG_LOG2) - 1);

  touch_state_e      state_q, state_d;
  logic [DcntW-1:0]  dcnt_q, dcnt_d;
  logic [ScntW-1:0]  scnt_q, scnt_d;
  logic [AccW-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [DispXW-1:0] pend_x_q, disp_x_q, disp_x_d;
  logic [DispYW-1:0] pend_y_q, disp_y_q, disp_y_d;
  logic              pend_valid_q, pend_valid_d;
  logic              clr_pend_q, clr_pend_d;
  logic              disp_valid_q, disp_valid_d;
  logic              press_q, press_d, release_q, release_d;

  logic              touched, accumulate, pend_wr, clr_set;
  logic [AccW-1:0]   sum_x, sum_y;
  logic [RAW_W-1:0]  avg_x, avg_y;
  logic [DispXW-1:0] cal_x;
  logic [DispYW-1:0] cal_y;

  assign touched = (raw_z >= RAW_W'(Z_THRESH));
  // Average includes the sample arriving now, so the final strobe feeds calib directly.
  assign sum_x   = acc_x_q + AccW'(raw_x);
  assign sum_y   = acc_y_q + AccW'(raw_y);
  assign avg_x   = RAW_W'(sum_x >> AVG_LOG2);
  assign avg_y   = RAW_W'(sum_y >> AVG_LOG2);

  touch_calib #(
    .IN_W  (RAW_W),
    .OUT_W (DispXW),
    .OFFSET(X_OFFSET),
    .SHIFT (SHIFT),
    .MAX   (X_MAX)
  ) u_calib_x (
    .avg(avg_x),
    .pix(cal_x)
  );

  touch_calib #(
    .IN_W  (RAW_W),
    .OUT_W (DispYW),
    .OFFSET(Y_OFFSET),
    .SHIFT (SHIFT),
    .MAX   (Y_MAX)
  ) u_calib_y (
    .avg(avg_y),
    .pix(cal_y)
  );

  // Debounce FSM and sample accumulator.
  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    scnt_d     = scnt_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    accumulate = 1'b0;
    pend_wr    = 1'b0;
    press_d    = 1'b0;
    release_d  = 1'b0;
    clr_set    = 1'b0;
    if (sample_stb) begin
      unique case (state_q)
        StIdle: begin
          if (touched) begin
            state_d = StDebP;
            dcnt_d  = DcntW'(1);
          end
        end
        StDebP: begin
          if (!touched) begin
            state_d = StIdle;
          end else if (dcnt_q == DcntLast) begin
            state_d = StTrack;
            press_d = 1'b1;
            acc_x_d = '0;
            acc_y_d = '0;
            scnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DcntW'(1);
          end
        end
        StTrack: begin
          if (touched) begin
            accumulate = 1'b1;
          end else begin
            state_d = StDebR;
            dcnt_d  = DcntW'(1);
          end
        end
        StDebR: begin
          if (touched) begin
            state_d    = StTrack;
            accumulate = 1'b1;
          end else if (dcnt_q == DcntLast) begin
            state_d   = StIdle;
            release_d = 1'b1;
            clr_set   = 1'b1;
            acc_x_d   = '0;
            acc_y_d   = '0;
            scnt_d    = '0;
          end else begin
            dcnt_d = dcnt_q + DcntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (accumulate) begin
      if (scnt_q == ScntLast) begin
        pend_wr = 1'b1;
        acc_x_d = '0;
        acc_y_d = '0;
        scnt_d  = '0;
      end else begin
        acc_x_d = sum_x;
        acc_y_d = sum_y;
        scnt_d  = scnt_q + ScntW'(1);
      end
    end
  end

  // Frame commit. Commit sees the pending slot as it was before this cycle's write,
  // so a value written alongside new_frame waits for the next frame.
  always_comb begin
    disp_x_d     = disp_x_q;
    disp_y_d     = disp_y_q;
    disp_valid_d = disp_valid_q;
    pend_valid_d = pend_valid_q;
    clr_pend_d   = clr_pend_q;
    if (new_frame) begin
      if (clr_pend_q) begin
        disp_valid_d = 1'b0;
        pend_valid_d = 1'b0;
        clr_pend_d   = 1'b0;
      end else if (pend_valid_q) begin
        disp_x_d     = pend_x_q;
        disp_y_d     = pend_y_q;
        disp_valid_d = 1'b1;
        pend_valid_d = 1'b0;
      end
    end
    if (pend_wr) pend_valid_d = 1'b1;
    if (clr_set) clr_pend_d = 1'b1;
  end

  always_ff @(posedge cclk) begin
    if (reset) begin
      state_q      <= StIdle;
      dcnt_q       <= '0;
      scnt_q       <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_valid_q <= 1'b0;
      clr_pend_q   <= 1'b0;
      disp_x_q     <= '0;
      disp_y_q     <= '0;
      disp_valid_q <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      scnt_q       <= scnt_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      if (pend_wr) begin
        pend_x_q <= cal_x;
        pend_y_q <= cal_y;
      end
      pend_valid_q <= pend_valid_d;
      clr_pend_q   <= clr_pend_d;
      disp_x_q     <= disp_x_d;
      disp_y_q     <= disp_y_d;
      disp_valid_q <= disp_valid_d;
      press_q      <= press_d;
      release_q    <= release_d;
    end
  end

  assign disp_x      = disp_x_q;
  assign disp_y      = disp_y_q;
  assign disp_valid  = disp_valid_q;
  assign press_evt   = press_q;
  assign release_evt = release_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_touch_frame_sync.sv
// Directed bench for touch_frame_sync with default parameters. Each vector drives
// one clock cycle of inputs and lists the outputs expected just after that edge.
module tb_touch_frame_sync;

  localparam int TZ = 300;  // touched pressure
  localparam int UZ = 100;  // untouched pressure

  logic        cclk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_stb = 1'b0;
  logic [11:0] raw_x = '0, raw_y = '0, raw_z = '0;
  logic        new_frame = 1'b0;
  logic [9:0]  disp_x;
  logic [8:0]  disp_y;
  logic        disp_valid, press_evt, release_evt;
  logic [1:0]  fsm_state;

  always #5 cclk = ~cclk;

  touch_frame_sync dut (
    .cclk       (cclk),
    .reset      (reset),
    .sample_stb (sample_stb),
    .raw_x      (raw_x),
    .raw_y      (raw_y),
    .raw_z      (raw_z),
    .new_frame  (new_frame),
    .disp_x     (disp_x),
    .disp_y     (disp_y),
    .disp_valid (disp_valid),
    .press_evt  (press_evt),
    .release_evt(release_evt),
    .fsm_state  (fsm_state)
  );

  typedef struct {
    logic        rst;
    logic        stb;
    logic [11:0] x, y, z;
    logic        nf;
    logic [9:0]  ex;
    logic [8:0]  ey;
    logic        ev, ep, er;
    logic [1:0]  es;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, input logic stb, input int x, input int y,
                              input int z, input logic nf, input int ex, input int ey,
                              input logic ev, input logic ep, input logic er, input int es);
    vec_t v;
    v.rst = rst; v.stb = stb; v.x = 12'(x); v.y = 12'(y); v.z = 12'(z); v.nf = nf;
    v.ex = 10'(ex); v.ey = 9'(ey); v.ev = ev; v.ep = ep; v.er = er; v.es = 2'(es);
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge cclk);
    reset = v.rst; sample_stb = v.stb; raw_x = v.x; raw_y = v.y; raw_z = v.z;
    new_frame = v.nf;
    @(posedge cclk);
    #1;
    checks++;
    if ({disp_x, disp_y, disp_valid, press_evt, release_evt, fsm_state} !==
        {v.ex, v.ey, v.ev, v.ep, v.er, v.es}) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d valid=%0b press=%0b rel=%0b st=%0d, want x=%0d y=%0d valid=%0b press=%0b rel=%0b st=%0d",
               tag, disp_x, disp_y, disp_valid, press_evt, release_evt, fsm_state,
               v.ex, v.ey, v.ev, v.ep, v.er, v.es);
    end
  endtask

  initial begin
    // Reset, debounced press, first average committed on new_frame.
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) add(mk(0, 1, 1000, 1000, TZ, 0, 0, 0, 0, 0, 0, 1));
    add(mk(0, 1, 1000, 1000, TZ, 0, 0, 0, 0, 1, 0, 2));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    for (int i = 0; i < 4; i++) add(mk(0, 1, 1000, 1000, TZ, 0, 0, 0, 0, 0, 0, 2));
    add(mk(0, 0, 0, 0, 0, 1, 106, 87, 1, 0, 0, 2));
    add(mk(0, 0, 0, 0, 0, 0, 106, 87, 1, 0, 0, 2));
    // Saturate x to 0, clamp y to 271.
    for (int i = 0; i < 4; i++) add(mk(0, 1, 100, 4095, TZ, 0, 106, 87, 1, 0, 0, 2));
    add(mk(0, 0, 0, 0, 0, 1, 0, 271, 1, 0, 0, 2));
    // Pending set, then release: release beats pending at the next frame.
    for (int i = 0; i < 4; i++) add(mk(0, 1, 1000, 1000, TZ, 0, 0, 271, 1, 0, 0, 2));
    for (int i = 0; i < 3; i++) add(mk(0, 1, 0, 0, UZ, 0, 0, 271, 1, 0, 0, 3));
    add(mk(0, 1, 0, 0, UZ, 0, 0, 271, 1, 0, 1, 0));
    add(mk(0, 0, 0, 0, 0, 1, 0, 271, 0, 0, 0, 0));
    add(mk(0, 0, 0, 0, 0, 1, 0, 271, 0, 0, 0, 0));
    // Bouncing contact, including the z threshold boundary.
    add(mk(0, 1, 500, 500, 256, 0, 0, 271, 0, 0, 0, 1));
    add(mk(0, 1, 500, 500, 255, 0, 0, 271, 0, 0, 0, 0));
    add(mk(0, 1, 500, 500, TZ, 0, 0, 271, 0, 0, 0, 1));
    add(mk(0, 1, 500, 500, UZ, 0, 0, 271, 0, 0, 0, 0));
    add(mk(0, 1, 500, 500, TZ, 0, 0, 271, 0, 0, 0, 1));
    add(mk(0, 1, 500, 500, TZ, 0, 0, 271, 0, 0, 0, 1));
    add(mk(0, 1, 500, 500, UZ, 0, 0, 271, 0, 0, 0, 0));
    // Short lift in TRACK: untouched sample must not enter the average.
    for (int i = 0; i < 3; i++) add(mk(0, 1, 1000, 1000, TZ, 0, 0, 271, 0, 0, 0, 1));
    add(mk(0, 1, 1000, 1000, TZ, 0, 0, 271, 0, 1, 0, 2));
    add(mk(0, 1, 2000, 2000, TZ, 0, 0, 271, 0, 0, 0, 2));
    add(mk(0, 1, 0, 0, UZ, 0, 0, 271, 0, 0, 0, 3));
    for (int i = 0; i < 3; i++) add(mk(0, 1, 2000, 2000, TZ, 0, 0, 271, 0, 0, 0, 2));
    add(mk(0, 0, 0, 0, 0, 1, 231, 212, 1, 0, 0, 2));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Pending written in the same cycle as new_frame: old display kept for a frame.
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 1000, 1000, TZ, 0, 231, 212, 1, 0, 0, 2), "same_frame_fill");
    apply(mk(0, 1, 1000, 1000, TZ, 1, 231, 212, 1, 0, 0, 2), "same_frame_hold");
    apply(mk(0, 0, 0, 0, 0, 0, 231, 212, 1, 0, 0, 2), "same_frame_idle");
    apply(mk(0, 0, 0, 0, 0, 1, 106, 87, 1, 0, 0, 2), "same_frame_next");

    // Reset while tracking.
    apply(mk(1, 1, 1000, 1000, TZ, 1, 0, 0, 0, 0, 0, 0), "reset_track");

    // Reset in DEB_R on the strobe that would otherwise release.
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 1000, 1000, TZ, 0, 0, 0, 0, 0, 0, 1), "rdebr_press");
    apply(mk(0, 1, 1000, 1000, TZ, 0, 0, 0, 0, 1, 0, 2), "rdebr_pressevt");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 0, 0, UZ, 0, 0, 0, 0, 0, 0, 3), "rdebr_lift");
    apply(mk(1, 1, 0, 0, UZ, 0, 0, 0, 0, 0, 0, 0), "reset_debr");
    apply(mk(0, 1, 0, 0, UZ, 0, 0, 0, 0, 0, 0, 0), "after_reset_debr");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "after_reset_frame");

    // Reset in DEB_P on the strobe that would otherwise press.
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 1000, 1000, TZ, 0, 0, 0, 0, 0, 0, 1), "rdebp_press");
    apply(mk(1, 1, 1000, 1000, TZ, 0, 0, 0, 0, 0, 0, 0), "reset_debp");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "after_reset_debp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
